vend_ctrl_multi: RTL
====================

// Module: vend_ctrl_multi
// PURPOSE
//  Parametrised vending controller: card insert, two-digit item code entry, payment wait, door handshake.
//  Generalises the fixed 20-item machine to NUM_ITEMS slots with per-item stock counters and configurable timeout.
//  Adds a SOLD_OUT flag and an optional sales audit counter. Sits between keypad/card/door I/O and the vend actuator.
// PARAMETERS
//  NUM_ITEMS  20  item count; valid codes 0..NUM_ITEMS-1 (max 100); code = 10*d1 + d2
//  STOCK_MAX  10  stock loaded per item on RELOAD
//  TIMEOUT    5   cycles allowed per wait state before abort
//  DIGIT_W    4   ITEM_CODE width; digit values > 9 are invalid
//  COST_W     3   COST width
// PORTS
//  CLK          in   1        rising-edge clock
//  RESET_N      in   1        asynchronous active-low reset
//  CARD_IN      in   1        card present (level)
//  VALID_TRAN   in   1        payment approved (level)
//  ITEM_CODE    in   DIGIT_W  keypad digit, sampled on KEY_PRESS rising edge
//  KEY_PRESS    in   1        keypad strobe (edge-detected internally)
//  DOOR_OPEN    in   1        delivery door open (level)
//  RELOAD       in   1        restock all items (honoured in IDLE only)
//  VEND         out  1        item release
//  INVALID_SEL  out  1        bad/empty selection or key timeout
//  FAILED_TRAN  out  1        payment timeout
//  COST         out  COST_W   price of the selected item
//  SOLD_OUT     out  1        all stock counters zero
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; all stock = 0 (machine needs RELOAD); timer 0; SOLD_OUT=1 after the first clock.
//  All outputs registered. A state's outputs appear on the cycle after the transition edge.
//  States and transitions:
//   IDLE: RELOAD=1 -> RELOAD state (wins over CARD_IN). CARD_IN=1 -> WAIT_D1.
//   RELOAD: every count = STOCK_MAX; back to IDLE next cycle.
//   WAIT_D1: key edge -> latch d1, go to WAIT_D2. TIMEOUT cycles with no edge -> ERR_SEL.
//   WAIT_D2: key edge -> latch d2, go to CHECK. Timeout -> ERR_SEL.
//   CHECK (1 cycle): digit>9, code>=NUM_ITEMS or stock==0 -> ERR_SEL.
//     Otherwise COST <= item_cost(code), go to WAIT_TRAN.
//   WAIT_TRAN: VALID_TRAN=1 -> VEND_OUT; stock[code] decrements the same edge. Timeout -> ERR_TRAN.
//   VEND_OUT: VEND=1. DOOR_OPEN=1 -> WAIT_CLOSE. Timeout -> DONE (item counted as sold, no refund).
//   WAIT_CLOSE: VEND=1 until DOOR_OPEN=0 (no timeout), then DONE.
//   DONE: all outputs 0, COST cleared; CARD_IN=0 -> IDLE.
//   ERR_SEL: INVALID_SEL=1 held until CARD_IN=0, then IDLE.
//   ERR_TRAN: FAILED_TRAN=1 held until CARD_IN=0, then IDLE.
//  Timer: cleared on every state change; abort fires when it reaches TIMEOUT with no qualifying event.
//   Event and timeout on the same cycle: the event wins.
//  KEY_PRESS: only 0->1 transitions count. A key held across a state change does not register twice.
//  CARD_IN dropping mid-entry does not abort; only timeouts abort (card level is checked in IDLE/DONE/ERR_*).
//  item_cost(c) = min(c/4 + 1, 2**COST_W - 1). Stock counter width is $clog2(STOCK_MAX+1); it never underflows.
//  Asserting RESET_N low mid-transaction aborts immediately and empties all stock.
// CONFIGURATION
//  VEND_AUDIT_EN defined: extra port SALES_TOTAL out 16.
//   It increments by item_cost(code) on each WAIT_TRAN->VEND_OUT edge, saturates at 16'hFFFF, and resets to 0.
//   RELOAD does not clear it.
//  VEND_AUDIT_EN undefined: no SALES_TOTAL port or logic; behaviour otherwise identical.
// STRUCTURE
//  Package vend_pkg: state enum; item_cost function; DIGIT_MAX=9 constant.
//  Sub-module vend_stock_bank (NUM_ITEMS counters with load-all, decrement-one, per-item empty read and all-empty flag).
//  Top level holds the FSM, timer, key edge detector and output registers.
// TESTING
//  1. RESET_N pulse; RELOAD 1 cycle; card in; keys 1 then 3; VALID_TRAN; DOOR_OPEN then close; card out
//     -> COST=4, VEND=1 until the door closes, stock[13]=9, back in IDLE.
//  2. Reset with no RELOAD; card in; keys 0,2 -> INVALID_SEL=1 (stock empty), SOLD_OUT=1; clears when CARD_IN=0.
//  3. After reload: card in, no key for 5 cycles -> INVALID_SEL=1.
//     Keys 2,7 with NUM_ITEMS=20 -> INVALID_SEL=1. Digit 12 -> INVALID_SEL=1.
//  4. Keys 0,7, VALID_TRAN held low 5 cycles -> FAILED_TRAN=1, COST=2, stock[7] unchanged.
//  5. STOCK_MAX=1: vend item 5 once -> second select of 5 -> INVALID_SEL.
//     Vend all items -> SOLD_OUT=1. RELOAD concurrent with CARD_IN -> reload first.
//  6. VEND_AUDIT_EN: vend items 13 (cost 4) and 19 (cost 5) -> SALES_TOTAL=9.
//     RESET_N asserted during WAIT_TRAN -> all outputs 0 immediately.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-item vending controller.
package vend_pkg;

  localparam int unsigned DIGIT_MAX = 9;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RELOAD,
    ST_WAIT_D1,
    ST_WAIT_D2,
    ST_CHECK,
    ST_WAIT_TRAN,
    ST_VEND_OUT,
    ST_WAIT_CLOSE,
    ST_DONE,
    ST_ERR_SEL,
    ST_ERR_TRAN
  } vend_state_e;

  // Price rises by one every four slots and saturates at the COST field maximum.
  function automatic int unsigned item_cost(input int unsigned code, input int unsigned cost_w);
    int unsigned c;
    int unsigned cap;
    c   = code / 4 + 1;
    cap = (32'd1 << cost_w) - 1;
    return (c > cap) ? cap : c;
  endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters: load-all, decrement-one (never below zero),
// per-item empty lookup and an all-empty flag.
module vend_stock_bank #(
  parameter int unsigned NUM_ITEMS = 20,
  parameter int unsigned STOCK_MAX = 10,
  parameter int unsigned IDX_W     = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_all_i,
  input  logic             dec_en_i,
  input  logic [IDX_W-1:0] dec_idx_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_empty_o,
  output logic             all_empty_o
);

  localparam int unsigned CNT_W = $clog2(STOCK_MAX + 1);

  logic [CNT_W-1:0] cnt_q [NUM_ITEMS];
  logic [CNT_W-1:0] cnt_d [NUM_ITEMS];

  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (load_all_i) begin
        cnt_d[i] = CNT_W'(STOCK_MAX);
      end else if (dec_en_i && (dec_idx_i == IDX_W'(i)) && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_ITEMS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    rd_empty_o  = 1'b0;
    all_empty_o = 1'b1;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (rd_idx_i == IDX_W'(i)) rd_empty_o = (cnt_q[i] == '0);
      if (cnt_q[i] != '0) all_empty_o = 1'b0;
    end
  end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Vending controller: card, two-digit code, payment, door handshake, per-item stock.
// Define VEND_AUDIT_EN to add the saturating SALES_TOTAL audit counter.
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int unsigned NUM_ITEMS = 20,
  parameter int unsigned STOCK_MAX = 10,
  parameter int unsigned TIMEOUT   = 5,
  parameter int unsigned DIGIT_W   = 4,
  parameter int unsigned COST_W    = 3
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               CARD_IN,
  input  logic               VALID_TRAN,
  input  logic [DIGIT_W-1:0] ITEM_CODE,
  input  logic               KEY_PRESS,
  input  logic               DOOR_OPEN,
  input  logic               RELOAD,
  output logic               VEND,
  output logic               INVALID_SEL,
  output logic               FAILED_TRAN,
  output logic [COST_W-1:0]  COST,
  output logic               SOLD_OUT,
`ifdef VEND_AUDIT_EN
  output logic [15:0]        SALES_TOTAL,
`endif
  output vend_state_e        STATE_DBG
);

  localparam int unsigned IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  vend_state_e        state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               key_prev_q;
  logic [DIGIT_W-1:0] d1_q, d1_d, d2_q, d2_d;
  logic [COST_W-1:0]  cost_q, cost_d;
  logic               vend_q, vend_d, inv_q, inv_d, fail_q, fail_d;
  logic               sold_q;

  logic               key_edge, timed_out, code_ok, load_all, dec_en;
  logic               rd_empty, all_empty;
  logic [IDX_W-1:0]   rd_idx;
  int unsigned        code_int;

  // Single-cycle pulse on a 0->1 keypad transition; a held key counts once.
  assign key_edge  = KEY_PRESS & ~key_prev_q;
  assign timed_out = (timer_q == TMR_W'(TIMEOUT - 1));

  always_comb begin
    code_int = 10 * 32'(d1_q) + 32'(d2_q);
    code_ok  = (32'(d1_q) <= DIGIT_MAX) && (32'(d2_q) <= DIGIT_MAX) && (code_int < NUM_ITEMS);
    rd_idx   = code_ok ? IDX_W'(code_int) : '0;
  end

  assign load_all = (state_q == ST_RELOAD);
  assign dec_en   = (state_q == ST_WAIT_TRAN) && VALID_TRAN;

  vend_stock_bank #(
    .NUM_ITEMS (NUM_ITEMS),
    .STOCK_MAX (STOCK_MAX),
    .IDX_W     (IDX_W)
  ) u_stock (
    .clk_i       (CLK),
    .rst_ni      (RESET_N),
    .load_all_i  (load_all),
    .dec_en_i    (dec_en),
    .dec_idx_i   (rd_idx),
    .rd_idx_i    (rd_idx),
    .rd_empty_o  (rd_empty),
    .all_empty_o (all_empty)
  );

  always_comb begin
    state_d = state_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    unique case (state_q)
      ST_IDLE: begin
        if (RELOAD)       state_d = ST_RELOAD;
        else if (CARD_IN) state_d = ST_WAIT_D1;
      end
      ST_RELOAD: state_d = ST_IDLE;
      ST_WAIT_D1: begin
        if (key_edge) begin
          d1_d    = ITEM_CODE;
          state_d = ST_WAIT_D2;
        end else if (timed_out) begin
          state_d = ST_ERR_SEL;
        end
      end
      ST_WAIT_D2: begin
        if (key_edge) begin
          d2_d    = ITEM_CODE;
          state_d = ST_CHECK;
        end else if (timed_out) begin
          state_d = ST_ERR_SEL;
        end
      end
      ST_CHECK: state_d = (code_ok && !rd_empty) ? ST_WAIT_TRAN : ST_ERR_SEL;
      ST_WAIT_TRAN: begin
        if (VALID_TRAN)     state_d = ST_VEND_OUT;
        else if (timed_out) state_d = ST_ERR_TRAN;
      end
      ST_VEND_OUT: begin
        if (DOOR_OPEN)      state_d = ST_WAIT_CLOSE;
        else if (timed_out) state_d = ST_DONE;
      end
      ST_WAIT_CLOSE: if (!DOOR_OPEN) state_d = ST_DONE;
      ST_DONE, ST_ERR_SEL, ST_ERR_TRAN: if (!CARD_IN) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register on the transition edge.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q)              timer_d = '0;
    else if (timer_q != TMR_W'(TIMEOUT)) timer_d = timer_q + 1'b1;

    cost_d = cost_q;
    if (state_q == ST_CHECK && state_d == ST_WAIT_TRAN)
      cost_d = COST_W'(item_cost(code_int, COST_W));
    else if (state_d == ST_IDLE || state_d == ST_DONE)
      cost_d = '0;

    vend_d = (state_d == ST_VEND_OUT) || (state_d == ST_WAIT_CLOSE);
    inv_d  = (state_d == ST_ERR_SEL);
    fail_d = (state_d == ST_ERR_TRAN);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      key_prev_q <= 1'b0;
      d1_q       <= '0;
      d2_q       <= '0;
      cost_q     <= '0;
      vend_q     <= 1'b0;
      inv_q      <= 1'b0;
      fail_q     <= 1'b0;
      sold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      key_prev_q <= KEY_PRESS;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      cost_q     <= cost_d;
      vend_q     <= vend_d;
      inv_q      <= inv_d;
      fail_q     <= fail_d;
      sold_q     <= all_empty;
    end
  end

`ifdef VEND_AUDIT_EN
  logic [15:0] sales_q, sales_d;
  logic [16:0] sales_sum;

  // cost_q holds item_cost(code) throughout WAIT_TRAN.
  always_comb begin
    sales_sum = 17'(sales_q) + 17'(cost_q);
    sales_d   = sales_q;
    if (dec_en) sales_d = sales_sum[16] ? 16'hFFFF : sales_sum[15:0];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) sales_q <= '0;
    else          sales_q <= sales_d;
  end

  assign SALES_TOTAL = sales_q;
`endif

  assign VEND        = vend_q;
  assign INVALID_SEL = inv_q;
  assign FAILED_TRAN = fail_q;
  assign COST        = cost_q;
  assign SOLD_OUT    = sold_q;
  assign STATE_DBG   = state_q;

endmodule
